// File: rtl/ysyx_23060191_ifu_pkg.sv
// Shared IFU definitions: datapath width, default boot address and FSM encoding.
package ysyx_23060191_ifu_pkg;

    localparam int unsigned CPU_WIDTH        = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060191_ifu_if.sv
// IFU bundle: instruction-memory port, EXU redirect/halt inputs and IDU handoff.
interface ysyx_23060191_ifu_if
    import ysyx_23060191_ifu_pkg::*;
#(
    parameter int unsigned W = CPU_WIDTH
);
    logic [W-1:0]  mem_pc;
    logic          mem_rd_en;
    logic [W-1:0]  mem_inst;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          halt_req;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_inst;
    logic [W-1:0]  out_pc;
    logic [31:0]   fetch_cnt;
    logic          halted;

    modport master (
        output mem_pc, mem_rd_en, out_valid, out_inst, out_pc, fetch_cnt, halted,
        input  mem_inst, redirect_valid, redirect_pc, halt_req, out_ready
    );

    modport slave (
        input  mem_pc, mem_rd_en, out_valid, out_inst, out_pc, fetch_cnt, halted,
        output mem_inst, redirect_valid, redirect_pc, halt_req, out_ready
    );
endinterface

// File: rtl/ysyx_23060191_ifu.sv
// Instruction fetch unit: BOOT/RUN/HALT sequencer with a one-entry output register
// towards IDU, redirect flush and halt freeze.
module ysyx_23060191_ifu
    import ysyx_23060191_ifu_pkg::*;
#(
    parameter int unsigned W        = CPU_WIDTH,
    parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEFAULT)
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_23060191_ifu_if.master        bus
);

    ifu_state_e    state_q, state_d;
    logic [W-1:0]  pc_q, pc_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_inst_q, out_inst_d;
    logic [W-1:0]  out_pc_q, out_pc_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;

    logic          fetch_go;
    logic          handoff;
    logic          active;
    logic [W-1:0]  redirect_aligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: halt is sticky until reset
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = bus.halt_req ? ST_HALT : ST_RUN;
            ST_RUN:  if (bus.halt_req) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // FSM outputs
    always_comb begin
        fetch_go = !rst && (state_q == ST_RUN) && !bus.halt_req && !bus.redirect_valid
                   && (!out_valid_q || bus.out_ready);
        bus.mem_rd_en = fetch_go;
        bus.halted    = (state_q == ST_HALT);
    end

    // Datapath: halt beats redirect, redirect beats fetch
    always_comb begin
        active           = (state_q != ST_HALT);
        handoff          = out_valid_q && bus.out_ready;
        redirect_aligned = bus.redirect_pc & ~W'(3);

        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        fetch_cnt_d = fetch_cnt_q;

        if (active && handoff) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end

        if (!active) begin
            out_valid_d = 1'b0;
        end else if (bus.halt_req) begin
            out_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
            pc_d        = redirect_aligned;
            out_valid_d = 1'b0;
        end else if (fetch_go) begin
            out_inst_d  = bus.mem_inst;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + W'(4);
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign bus.mem_pc    = pc_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Directed bench for the IFU: boot, backpressure, redirect, wrap, reset and halt.
module tb_ysyx_23060191_ifu;
    import ysyx_23060191_ifu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_23060191_ifu_if #(.W(32)) bus ();

    ysyx_23060191_ifu #(.W(32), .RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: word content derived from its address
    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    assign bus.mem_inst = ins(bus.mem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        bus.out_ready      = 1'b1;
        bus.halt_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_pc",     bus.mem_pc, 32'h8000_0000);
        chk("rst_cnt",    bus.fetch_cnt, 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_outpc",  bus.out_pc, 32'd0);
        chk("rst_inst",   bus.out_inst, 32'd0);
        chk("rst_rden",   32'(bus.mem_rd_en), 32'd0);

        // Boot sequence
        rst = 1'b0;
        settle();
        chk("boot_rden", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("run_rden",  32'(bus.mem_rd_en), 32'd1);
        chk("run_pc",    bus.mem_pc, 32'h8000_0000);
        chk("run_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("f0_valid", 32'(bus.out_valid), 32'd1);
        chk("f0_outpc", bus.out_pc, 32'h8000_0000);
        chk("f0_inst",  bus.out_inst, ins(32'h8000_0000));
        chk("f0_pc",    bus.mem_pc, 32'h8000_0004);
        chk("f0_cnt",   bus.fetch_cnt, 32'd0);
        tick();
        chk("f1_outpc", bus.out_pc, 32'h8000_0004);
        chk("f1_cnt",   bus.fetch_cnt, 32'd1);
        chk("f1_pc",    bus.mem_pc, 32'h8000_0008);
        tick();
        chk("f2_outpc", bus.out_pc, 32'h8000_0008);
        chk("f2_cnt",   bus.fetch_cnt, 32'd2);
        chk("f2_pc",    bus.mem_pc, 32'h8000_000C);

        // Backpressure for three cycles
        bus.out_ready = 1'b0;
        settle();
        chk("bp_rden0", 32'(bus.mem_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_outpc", bus.out_pc, 32'h8000_0008);
            chk("bp_inst",  bus.out_inst, ins(32'h8000_0008));
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_rden",  32'(bus.mem_rd_en), 32'd0);
            chk("bp_pc",    bus.mem_pc, 32'h8000_000C);
            chk("bp_cnt",   bus.fetch_cnt, 32'd2);
        end
        bus.out_ready = 1'b1;
        settle();
        chk("bp_rel_rden", 32'(bus.mem_rd_en), 32'd1);
        tick();
        chk("bp_rel_outpc", bus.out_pc, 32'h8000_000C);
        chk("bp_rel_cnt",   bus.fetch_cnt, 32'd3);
        chk("bp_rel_pc",    bus.mem_pc, 32'h8000_0010);

        // Redirect flushes an unaccepted instruction
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        settle();
        chk("rd_rden", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("rd_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_pc",    bus.mem_pc, 32'h8000_0100);
        chk("rd_cnt",   bus.fetch_cnt, 32'd3);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        tick();
        chk("rd_f_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_f_outpc", bus.out_pc, 32'h8000_0100);
        chk("rd_f_pc",    bus.mem_pc, 32'h8000_0104);
        chk("rd_f_cnt",   bus.fetch_cnt, 32'd3);
        tick();
        chk("rd_f2_cnt",   bus.fetch_cnt, 32'd4);
        chk("rd_f2_outpc", bus.out_pc, 32'h8000_0104);

        // PC wrap: redirect near the top of the address space, accepted flush counts
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFE;
        tick();
        chk("wr_valid", 32'(bus.out_valid), 32'd0);
        chk("wr_pc",    bus.mem_pc, 32'hFFFF_FFFC);
        chk("wr_cnt",   bus.fetch_cnt, 32'd5);
        bus.redirect_valid = 1'b0;
        tick();
        chk("wr_f_outpc", bus.out_pc, 32'hFFFF_FFFC);
        chk("wr_f_pc",    bus.mem_pc, 32'h0000_0000);
        tick();
        chk("wr_f2_outpc", bus.out_pc, 32'h0000_0000);
        chk("wr_f2_inst",  bus.out_inst, ins(32'h0000_0000));
        chk("wr_f2_pc",    bus.mem_pc, 32'h0000_0004);
        chk("wr_f2_cnt",   bus.fetch_cnt, 32'd6);

        // Counter wrap via preload
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        #1;
        chk("cw_pre", bus.fetch_cnt, 32'hFFFF_FFFF);
        tick();
        chk("cw_wrap",  bus.fetch_cnt, 32'd0);
        chk("cw_outpc", bus.out_pc, 32'h0000_0004);

        // Reset mid-operation with a pending instruction and a redirect
        rst                = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_1234;
        settle();
        chk("mr_rden", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("mr_valid",  32'(bus.out_valid), 32'd0);
        chk("mr_pc",     bus.mem_pc, 32'h8000_0000);
        chk("mr_cnt",    bus.fetch_cnt, 32'd0);
        chk("mr_outpc",  bus.out_pc, 32'd0);
        chk("mr_halted", 32'(bus.halted), 32'd0);

        // Redirect during BOOT still moves on to RUN
        rst             = 1'b0;
        bus.redirect_pc = 32'h8000_0203;
        settle();
        chk("br_rden", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("br_pc", bus.mem_pc, 32'h8000_0200);
        bus.redirect_valid = 1'b0;
        settle();
        chk("br_run_rden", 32'(bus.mem_rd_en), 32'd1);
        tick();
        chk("br_f_valid", 32'(bus.out_valid), 32'd1);
        chk("br_f_outpc", bus.out_pc, 32'h8000_0200);
        chk("br_f_pc",    bus.mem_pc, 32'h8000_0204);

        // Halt beats a simultaneous redirect
        bus.halt_req       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h9000_0000;
        settle();
        chk("h_rden", 32'(bus.mem_rd_en), 32'd0);
        tick();
        chk("h_halted", 32'(bus.halted), 32'd1);
        chk("h_valid",  32'(bus.out_valid), 32'd0);
        chk("h_pc",     bus.mem_pc, 32'h8000_0204);
        chk("h_cnt",    bus.fetch_cnt, 32'd1);
        bus.halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.redirect_valid = (i % 2 == 0);
            bus.redirect_pc    = 32'hA000_0000 + 32'(i * 16);
            settle();
            chk("hs_rden", 32'(bus.mem_rd_en), 32'd0);
            tick();
            chk("hs_pc",     bus.mem_pc, 32'h8000_0204);
            chk("hs_valid",  32'(bus.out_valid), 32'd0);
            chk("hs_cnt",    bus.fetch_cnt, 32'd1);
            chk("hs_halted", 32'(bus.halted), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060191_ifu.md
YSYX_23060191_IFU -- requirements
Module: ysyx_23060191_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter W, default `CPU_WIDTH (32): address/instruction width.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_pc  out  W: fetch address to instruction memory stage (combinational read, same-cycle data).
REQ-006 SHALL have port mem_rd_en  out  1: memory read enable.
REQ-007 SHALL have port mem_inst  in  W: instruction returned by memory for mem_pc in the same cycle.
REQ-008 SHALL have port redirect_valid  in  1: branch/jump taken, from EXU.
REQ-009 SHALL have port redirect_pc  in  W: redirect target.
REQ-010 SHALL have port halt_req  in  1: ebreak/halt request.
REQ-011 SHALL have port out_valid  out  1: out_inst/out_pc hold a valid fetched instruction.
REQ-012 SHALL have port out_ready  in  1: IDU accepts this cycle.
REQ-013 SHALL have port out_inst  out  W: registered instruction.
REQ-014 SHALL have port out_pc  out  W: address of out_inst.
REQ-015 SHALL have port fetch_cnt  out  32: count of accepted handoffs (out_valid && out_ready).
REQ-016 SHALL have port halted  out  1: high while in HALT.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT; BOOT -> RUN unconditionally after one cycle; RUN -> HALT on halt_req; HALT exits only by rst.
REQ-018 SHALL hold pc_q, with mem_pc = pc_q always.
REQ-019 SHALL compute fetch_go = (state==RUN) && !halt_req && !redirect_valid && (!out_valid || out_ready); mem_rd_en = fetch_go.
REQ-020 On fetch_go edge: out_inst <= mem_inst, out_pc <= pc_q, out_valid <= 1, pc_q <= pc_q + 4 (mod 2^W, wraps silently).
REQ-021 Handoff at edge where out_valid && out_ready && !fetch_go: out_valid <= 0.
REQ-022 Backpressure (out_valid && !out_ready): out_inst, out_pc, out_valid, pc_q held unchanged; mem_rd_en = 0.
REQ-023 Throughput one instruction/cycle when out_ready held high; fetch-to-out_valid latency one cycle.
REQ-024 Redirect edge (state==RUN): pc_q <= {redirect_pc[W-1:2], 2'b00}; out_valid <= 0 (pending instruction flushed even if unaccepted); no fetch that cycle.
REQ-025 Redirect during BOOT: pc_q <= aligned redirect_pc; BOOT -> RUN still occurs.
REQ-026 halt_req edge (RUN or BOOT): state <= HALT, out_valid <= 0; halt wins over simultaneous redirect (pc_q unchanged) and over fetch.
REQ-027 In HALT: mem_rd_en = 0, out_valid = 0, pc_q and fetch_cnt frozen, redirect_valid ignored.
REQ-028 fetch_cnt increments by 1 on each edge with out_valid && out_ready (including the flush cycle if out_ready was high before the flush); wraps 0xFFFF_FFFF -> 0.
REQ-029 out_valid SHALL never rise in the same cycle as redirect_valid or halt_req.

Reset
REQ-030 On rst edge: state <= BOOT, pc_q <= RESET_PC, out_valid <= 0, out_inst <= 0, out_pc <= 0, fetch_cnt <= 0; halted = 0.
REQ-031 rst mid-operation overrides all inputs, discarding pending instruction and redirects; mem_rd_en = 0 while rst high.

Structure
REQ-032 RESET_PC default, W, and state encoding (2-bit BOOT=0, RUN=1, HALT=2) SHALL live in shared defines file alongside `CPU_WIDTH.
REQ-033 SHALL be single module; memory read stays in the existing memory stage; no submodule.

Verification
REQ-034 Reset released, out_ready=1 -> cycle 1 mem_rd_en=0 (BOOT); cycle 2 mem_pc=0x80000000, rd_en=1; cycle 3 out_valid=1, out_pc=0x80000000, mem_pc=0x80000004.
REQ-035 out_ready=0 for 3 cycles with out_pc=0x80000008 -> out_inst/out_pc stable, rd_en=0, mem_pc=0x8000000C; out_ready=1 -> next edge out_pc=0x8000000C, fetch_cnt+1.
REQ-036 redirect_valid=1, redirect_pc=0x80000102, unaccepted instruction pending -> next cycle out_valid=0, mem_pc=0x80000100; cycle after out_pc=0x80000100.
REQ-037 halt_req and redirect_valid same cycle -> halted=1, out_valid=0, mem_pc unchanged, rd_en stays 0 for 10 cycles despite further redirects.
REQ-038 fetch_cnt preloaded 0xFFFFFFFF via long run (or force) + one handoff -> 0; pc_q 0xFFFFFFFC + fetch -> 0x00000000.
REQ-039 rst asserted while out_valid=1 and redirect_valid=1 -> next cycle out_valid=0, pc_q=0x80000000, fetch_cnt=0, state BOOT.
